// File: rtl/line_buffer_fill_pkg.sv
// -----------------------------------------------------------------------------
// line_buffer_fill_pkg
// Shared graphics definitions for the line-buffer fill path: pixel width,
// line-buffer half depth, display line width and the fill FSM state encoding
// (also exported on debug_state).
// -----------------------------------------------------------------------------
package line_buffer_fill_pkg;

    localparam int PIX_W         = 12;
    localparam int LB_HALF_DEPTH = 1024;
    localparam int DISP_W        = 640;
    localparam int X_W           = $clog2(LB_HALF_DEPTH);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        DRAIN = 3'd2,
        DONE  = 3'd3
    } lbf_state_e;

endpackage

// File: rtl/line_buffer_fill_rd_pipe.sv
// -----------------------------------------------------------------------------
// lbf_rd_pipe
// Tracks frame-buffer reads in flight: an RD_LAT-deep shift register carrying
// a valid bit and the column of each issued read, so ret_valid/ret_col line
// up with the cycle the read data appears on fb_dout.
// Ports:
//   clk        clock (rising edge)
//   reset_n    synchronous active-low reset
//   flush      discards every read in flight (valid bits cleared)
//   issue      a read is issued this cycle
//   issue_col  column of the issued read
//   ret_valid  read data for ret_col is on fb_dout this cycle
//   ret_col    column of the returning read
// -----------------------------------------------------------------------------
module lbf_rd_pipe #(
    parameter int RD_LAT = 2,
    parameter int COL_W  = 9
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             issue,
    input  logic [COL_W-1:0] issue_col,
    output logic             ret_valid,
    output logic [COL_W-1:0] ret_col
);

    logic [RD_LAT-1:0] vld;
    logic [COL_W-1:0]  col_sr [RD_LAT];

    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            vld <= '0;
        end else begin
            vld[0] <= issue;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                vld[i] <= vld[i-1];
            end
        end
    end

    // Column payload needs no reset: it is only looked at under vld.
    always_ff @(posedge clk) begin
        col_sr[0] <= issue_col;
        for (int unsigned i = 1; i < RD_LAT; i++) begin
            col_sr[i] <= col_sr[i-1];
        end
    end

    assign ret_valid = vld[RD_LAT-1];
    assign ret_col   = col_sr[RD_LAT-1];

endmodule

// File: rtl/line_buffer_fill.sv
// -----------------------------------------------------------------------------
// line_buffer_fill
// Fills one half of a ping-pong line buffer with a 2x horizontally upscaled
// display line per request. Each source row is used for two display lines.
// Ports:
//   clk_100     sole clock
//   reset_n     synchronous active-low reset
//   line_sync   one-cycle pulse per display line (starts a fill when idle)
//   frame_sync  one-cycle pulse per frame (restarts at row 0, aborts a fill)
//   fb_addr/fb_en/fb_dout  frame-buffer read port (data RD_LAT after fb_en)
//   lb_addr/lb_din/lb_we/lb_en  line-buffer write port {half, x}
//   busy        a fill is in progress
//   overrun     sticky: line_sync arrived while busy
//   debug_state current FSM state
// Build option: LBF_OVERRUN_DETECT_EN enables overrun detection; otherwise
// overrun is tied low (port list unchanged).
// -----------------------------------------------------------------------------
module line_buffer_fill
    import line_buffer_fill_pkg::*;
#(
    parameter int SRC_W  = 320,
    parameter int SRC_H  = 240,
    parameter int RD_LAT = 2
) (
    input  logic        clk_100,
    input  logic        reset_n,
    input  logic        line_sync,
    input  logic        frame_sync,
    output logic [17:0] fb_addr,
    output logic        fb_en,
    input  logic [11:0] fb_dout,
    output logic [10:0] lb_addr,
    output logic [15:0] lb_din,
    output logic        lb_we,
    output logic        lb_en,
    output logic        busy,
    output logic        overrun,
    output logic [2:0]  debug_state
);

    localparam int COL_W = $clog2(SRC_W + 1);
    localparam int ND_W  = $clog2(2 * SRC_H + 1);
    localparam logic [COL_W-1:0] COL_LAST   = COL_W'(SRC_W - 1);
    localparam logic [ND_W-1:0]  DISP_LINES = ND_W'(2 * SRC_H);
    localparam logic [X_W-1:0]   X_LAST     = X_W'(2 * SRC_W - 1);
    localparam logic [17:0]      ROW_STEP   = 18'(SRC_W);

    lbf_state_e       state, state_nxt;
    logic [COL_W-1:0] col;
    logic             phase;
    logic [17:0]      rd_addr;
    logic [17:0]      row_base;
    logic [ND_W-1:0]  next_disp;
    logic             wr_half;
    logic             dup_pending;
    logic             line_ok;
    logic             ret_valid;
    logic [COL_W-1:0] ret_col;

    // frame_sync takes precedence over a coincident line_sync.
    assign line_ok = line_sync && !frame_sync && (state == IDLE) &&
                     (next_disp < DISP_LINES);

    assign fb_en       = (state == FETCH) && !phase;
    assign fb_addr     = rd_addr;
    assign busy        = (state != IDLE);
    assign lb_en       = lb_we;
    assign debug_state = state;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (line_ok) state_nxt = FETCH;
            FETCH:   if (!phase && col == COL_LAST) state_nxt = DRAIN;
            DRAIN:   if (lb_we && lb_addr[X_W-1:0] == X_LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (frame_sync) state_nxt = FETCH;
    end

    always_ff @(posedge clk_100) begin
        if (!reset_n) begin
            state     <= IDLE;
            col       <= '0;
            phase     <= 1'b0;
            rd_addr   <= '0;
            row_base  <= '0;
            next_disp <= '0;
            wr_half   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (frame_sync) begin
                col       <= '0;
                phase     <= 1'b0;
                rd_addr   <= '0;
                row_base  <= '0;
                next_disp <= '0;
                wr_half   <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (line_ok) begin
                            col     <= '0;
                            phase   <= 1'b0;
                            rd_addr <= row_base;
                        end
                    end
                    FETCH: begin
                        // Reads go out on even phases; rd_addr tracks row_base + col.
                        phase <= ~phase;
                        if (!phase) begin
                            col     <= col + 1'b1;
                            rd_addr <= rd_addr + 18'd1;
                        end
                    end
                    DONE: begin
                        wr_half   <= ~wr_half;
                        next_disp <= next_disp + 1'b1;
                        // Odd display line finished: advance to the next source row.
                        if (next_disp[0]) row_base <= row_base + ROW_STEP;
                    end
                    default: ;
                endcase
            end
        end
    end

    lbf_rd_pipe #(
        .RD_LAT (RD_LAT),
        .COL_W  (COL_W)
    ) u_rd_pipe (
        .clk       (clk_100),
        .reset_n   (reset_n),
        .flush     (frame_sync),
        .issue     (fb_en),
        .issue_col (col),
        .ret_valid (ret_valid),
        .ret_col   (ret_col)
    );

    // Each returned pixel is written at x = 2*col, then held for x = 2*col+1.
    always_ff @(posedge clk_100) begin
        if (!reset_n) begin
            lb_we       <= 1'b0;
            lb_addr     <= '0;
            lb_din      <= '0;
            dup_pending <= 1'b0;
        end else if (frame_sync) begin
            lb_we       <= 1'b0;
            dup_pending <= 1'b0;
        end else if (ret_valid) begin
            lb_we       <= 1'b1;
            lb_addr     <= {wr_half, X_W'({ret_col, 1'b0})};
            lb_din      <= {4'b0000, fb_dout};
            dup_pending <= 1'b1;
        end else if (dup_pending) begin
            lb_addr[0]  <= 1'b1;
            dup_pending <= 1'b0;
        end else begin
            lb_we <= 1'b0;
        end
    end

`ifdef LBF_OVERRUN_DETECT_EN
    always_ff @(posedge clk_100) begin
        if (!reset_n) begin
            overrun <= 1'b0;
        end else if (line_sync && !frame_sync && busy) begin
            overrun <= 1'b1;
        end
    end
`else
    assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_line_buffer_fill.sv
module tb_line_buffer_fill;
    import line_buffer_fill_pkg::*;

    typedef struct packed {
        logic [10:0] addr;
        logic [15:0] din;
    } wr_t;

    logic clk_100 = 1'b0;
    always #5 clk_100 = ~clk_100;

    logic reset_n, line_sync, frame_sync;
    logic fs_s, ls_s;

    int n_chk  = 0;
    int n_pass = 0;

`ifdef LBF_OVERRUN_DETECT_EN
    localparam int EXP_OVR = 1;
`else
    localparam int EXP_OVR = 0;
`endif

    wr_t         wr_q [3][$];
    logic [17:0] rd_q [3][$];

    task automatic check(input logic ok, input string name, input int act, input int exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    task automatic check_eq(input string name, input int act, input int exp);
        check(act == exp, name, act, exp);
    endtask

    // Three full-size instances differing only in read latency, fed the same syncs.
    for (genvar k = 0; k < 3; k++) begin : g_lat
        localparam int L = k + 1;
        logic [17:0] fb_addr;
        logic        fb_en;
        logic [11:0] fb_dout;
        logic [10:0] lb_addr;
        logic [15:0] lb_din;
        logic        lb_we, lb_en, busy, overrun;
        logic [2:0]  debug_state;
        logic [11:0] fbq [L];
        logic        rst_seen = 1'b0, rst_prev = 1'b0, abort_seen = 1'b0, pend = 1'b0;
        int          cyc = 0, t0 = 0;

        line_buffer_fill #(.SRC_W(320), .SRC_H(240), .RD_LAT(L)) u_dut (
            .clk_100     (clk_100),
            .reset_n     (reset_n),
            .line_sync   (line_sync),
            .frame_sync  (frame_sync),
            .fb_addr     (fb_addr),
            .fb_en       (fb_en),
            .fb_dout     (fb_dout),
            .lb_addr     (lb_addr),
            .lb_din      (lb_din),
            .lb_we       (lb_we),
            .lb_en       (lb_en),
            .busy        (busy),
            .overrun     (overrun),
            .debug_state (debug_state)
        );

        // Frame-buffer model: pixel = addr[11:0], returned L cycles after fb_en.
        always @(posedge clk_100) begin
            fbq[0] <= fb_en ? fb_addr[11:0] : 12'hBAD;
            for (int i = 1; i < L; i++) fbq[i] <= fbq[i-1];
            rst_seen   <= !reset_n;
            rst_prev   <= rst_seen;
            abort_seen <= frame_sync || !reset_n;
        end
        assign fb_dout = fbq[L-1];

        // Monitor: pops the scoreboard whenever the DUT writes or reads.
        always @(negedge clk_100) begin
            wr_t         e;
            logic [17:0] ra;
            cyc++;
            if (rst_seen) begin
                check_eq($sformatf("L%0d rst fb_en", L), fb_en, 0);
                check_eq($sformatf("L%0d rst fb_addr", L), fb_addr, 0);
                check_eq($sformatf("L%0d rst lb_we", L), lb_we, 0);
                check_eq($sformatf("L%0d rst lb_addr", L), lb_addr, 0);
                check_eq($sformatf("L%0d rst lb_din", L), lb_din, 0);
                check_eq($sformatf("L%0d rst busy", L), busy, 0);
                check_eq($sformatf("L%0d rst overrun", L), overrun, 0);
                check_eq($sformatf("L%0d rst state", L), debug_state, 0);
            end else if (rst_prev) begin
                check_eq($sformatf("L%0d we after reset", L), lb_we, 0);
            end
            check_eq($sformatf("L%0d lb_en==lb_we", L), lb_en, lb_we);
            if (pend && !abort_seen)
                check_eq($sformatf("L%0d pair second write", L), lb_we, 1);
            pend = lb_we && !lb_addr[0];
            if (lb_we) begin
                check(wr_q[k].size() > 0, $sformatf("L%0d write expected", L), lb_addr, 0);
                if (wr_q[k].size() > 0) begin
                    e = wr_q[k].pop_front();
                    check_eq($sformatf("L%0d lb_addr", L), lb_addr, e.addr);
                    check_eq($sformatf("L%0d lb_din x=%0d", L, e.addr[9:0]), lb_din, e.din);
                end
            end
            if (fb_en) begin
                check(rd_q[k].size() > 0, $sformatf("L%0d read expected", L), fb_addr, 0);
                if (rd_q[k].size() > 0) begin
                    ra = rd_q[k].pop_front();
                    check_eq($sformatf("L%0d fb_addr", L), fb_addr, ra);
                end
            end
            if (reset_n && (frame_sync || (line_sync && debug_state == IDLE))) t0 = cyc;
            if (debug_state == DONE)
                check(cyc - t0 <= 643 + L, $sformatf("L%0d fill latency", L), cyc - t0, 643 + L);
        end
    end

    // Small instance for the end-of-frame limit (4 display lines).
    logic [17:0] fb_addr_s;
    logic        fb_en_s;
    logic [11:0] fb_dout_s;
    logic [10:0] lb_addr_s;
    logic [15:0] lb_din_s;
    logic        lb_we_s, lb_en_s, busy_s, overrun_s;
    logic [2:0]  debug_state_s;
    int          n_wr_s = 0, n_rd_s = 0;

    assign fb_dout_s = 12'h000;

    line_buffer_fill #(.SRC_W(4), .SRC_H(2), .RD_LAT(2)) u_small (
        .clk_100     (clk_100),
        .reset_n     (reset_n),
        .line_sync   (ls_s),
        .frame_sync  (fs_s),
        .fb_addr     (fb_addr_s),
        .fb_en       (fb_en_s),
        .fb_dout     (fb_dout_s),
        .lb_addr     (lb_addr_s),
        .lb_din      (lb_din_s),
        .lb_we       (lb_we_s),
        .lb_en       (lb_en_s),
        .busy        (busy_s),
        .overrun     (overrun_s),
        .debug_state (debug_state_s)
    );

    always @(negedge clk_100) begin
        if (reset_n) begin
            check_eq("S lb_en==lb_we", lb_en_s, lb_we_s);
            if (lb_we_s) begin
                n_wr_s++;
                check_eq("S lb_din", lb_din_s, 0);
                check(lb_addr_s[9:0] < 10'd8, "S lb_x range", lb_addr_s[9:0], 7);
            end
            if (fb_en_s) begin
                n_rd_s++;
                check(fb_addr_s < 18'd8, "S fb_addr range", fb_addr_s, 7);
            end
        end
    end

    task automatic tick();
        @(posedge clk_100);
        #1;
    endtask

    task automatic push_fill(input logic half, input int base);
        wr_t        w;
        logic [11:0] pix;
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < 320; c++) begin
                pix = 12'(base + c);
                rd_q[k].push_back(18'(base + c));
                w.addr = {half, 10'(2 * c)};
                w.din  = {4'h0, pix};
                wr_q[k].push_back(w);
                w.addr = {half, 10'(2 * c + 1)};
                wr_q[k].push_back(w);
            end
        end
    endtask

    task automatic clear_q();
        for (int k = 0; k < 3; k++) begin
            wr_q[k].delete();
            rd_q[k].delete();
        end
    endtask

    task automatic pulse_line();
        line_sync = 1'b1;
        tick();
        line_sync = 1'b0;
    endtask

    task automatic pulse_frame();
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((g_lat[0].busy || g_lat[1].busy || g_lat[2].busy) && n < 3000) begin
            tick();
            n++;
        end
        check_eq(name, {g_lat[2].busy, g_lat[1].busy, g_lat[0].busy}, 0);
    endtask

    task automatic wait_idle_s(input string name);
        int n = 0;
        while (busy_s && n < 200) begin
            tick();
            n++;
        end
        check_eq(name, busy_s, 0);
    endtask

    task automatic check_empty(input string name);
        for (int k = 0; k < 3; k++) begin
            check_eq($sformatf("%s wr_q L%0d", name, k + 1), wr_q[k].size(), 0);
            check_eq($sformatf("%s rd_q L%0d", name, k + 1), rd_q[k].size(), 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic found;
        logic busy_seen, en_seen;
        reset_n = 1'b0; line_sync = 1'b0; frame_sync = 1'b0;
        fs_s = 1'b0; ls_s = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();

        // Frame start: half 0, row 0, data = x>>1.
        push_fill(1'b0, 0);
        pulse_frame();
        wait_idle("frame fill idle");
        check_empty("frame fill");
        check_eq("overrun after frame", g_lat[1].overrun, 0);

        // Three line fills: halves 1,0,1 with bases 0,320,320.
        push_fill(1'b1, 0);
        pulse_line();
        wait_idle("line1 idle");
        push_fill(1'b0, 320);
        pulse_line();
        wait_idle("line2 idle");
        push_fill(1'b1, 320);
        pulse_line();
        wait_idle("line3 idle");
        check_empty("three lines");

        // line_sync 50 cycles into a fill is ignored (no extra fill follows).
        push_fill(1'b0, 640);
        pulse_line();
        repeat (48) tick();
        pulse_line();
        wait_idle("overrun fill idle");
        repeat (5) tick();
        check_empty("overrun fill");
        for (int k = 0; k < 3; k++) begin
            check_eq("overrun L1", g_lat[0].overrun, EXP_OVR);
            check_eq("overrun L2", g_lat[1].overrun, EXP_OVR);
            check_eq("overrun L3", g_lat[2].overrun, EXP_OVR);
        end

        // frame_sync at the write of x=300 aborts and restarts from half 0, addr 0.
        push_fill(1'b0, 0);
        pulse_frame();
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            if (g_lat[1].lb_we && g_lat[1].lb_addr[9:0] == 10'd300) found = 1'b1;
            else tick();
        end
        check_eq("abort x=300 reached", found, 1);
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        clear_q();
        push_fill(1'b0, 0);
        check_eq("abort lb_we L1", g_lat[0].lb_we, 0);
        check_eq("abort lb_we L2", g_lat[1].lb_we, 0);
        check_eq("abort lb_we L3", g_lat[2].lb_we, 0);
        check_eq("restart fb_en", g_lat[1].fb_en, 1);
        check_eq("restart fb_addr", g_lat[1].fb_addr, 0);
        wait_idle("restart idle");
        check_empty("restart fill");
        check_eq("overrun sticky", g_lat[1].overrun, EXP_OVR);

        // Reset mid-fill abandons it and returns to line 0 / half 0.
        push_fill(1'b1, 0);
        pulse_line();
        repeat (100) tick();
        reset_n = 1'b0;
        tick();
        clear_q();
        tick();
        reset_n = 1'b1;
        tick();
        check_eq("post-reset busy", g_lat[1].busy, 0);
        check_eq("post-reset overrun", g_lat[1].overrun, 0);
        push_fill(1'b0, 0);
        pulse_line();
        wait_idle("post-reset fill idle");
        check_empty("post-reset fill");

        // Small instance: all display lines filled, then a further line_sync is ignored.
        fs_s = 1'b1;
        tick();
        fs_s = 1'b0;
        wait_idle_s("small frame idle");
        repeat (3) begin
            ls_s = 1'b1;
            tick();
            ls_s = 1'b0;
            wait_idle_s("small line idle");
        end
        check_eq("small writes", n_wr_s, 32);
        check_eq("small reads", n_rd_s, 16);
        ls_s = 1'b1;
        tick();
        ls_s = 1'b0;
        busy_seen = 1'b0;
        en_seen   = 1'b0;
        repeat (20) begin
            busy_seen |= busy_s;
            en_seen   |= fb_en_s;
            tick();
        end
        check_eq("small busy after limit", busy_seen, 0);
        check_eq("small fb_en after limit", en_seen, 0);
        check_eq("small reads after limit", n_rd_s, 16);
        check_eq("small state idle", debug_state_s, 0);
        check_eq("small overrun", overrun_s, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
